// File: rtl/button_frontend.sv
// Push-button conditioning: polarity fix, 2-flop synchronizer, debounce,
// press/release strobes and a one-shot long-press strobe per channel.
module button_frontend #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int PAD_ACTIVE_LOW  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] level,
  output logic [N-1:0] down,
  output logic [N-1:0] up,
  output logic [N-1:0] long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_CYCLES);

  logic [N-1:0]  pad;
  logic [N-1:0]  sync1_q, sync1_d;
  logic [N-1:0]  sync2_q, sync2_d;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  down_q, down_d;
  logic [N-1:0]  up_q, up_d;
  logic [N-1:0]  long_q, long_d;
  logic [DW-1:0] db_cnt_q [N];
  logic [DW-1:0] db_cnt_d [N];
  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];

  always_comb begin
    pad     = (PAD_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    sync1_d = pad;
    sync2_d = sync1_q;
    level_d = level_q;
    down_d  = '0;
    up_d    = '0;
    long_d  = '0;
    for (int i = 0; i < N; i++) begin
      db_cnt_d[i] = '0;
      hold_d[i]   = '0;
      // Any sample matching the current level leaves the count at zero.
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_TC) level_d[i] = sync2_q[i];
        else                      db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      down_d[i] = level_d[i] & ~level_q[i];
      up_d[i]   = ~level_d[i] & level_q[i];
      // Hold counter saturates one past terminal count so the strobe fires once.
      if (level_d[i] && level_q[i]) begin
        hold_d[i] = (hold_q[i] != HOLD_SAT) ? hold_q[i] + 1'b1 : hold_q[i];
        long_d[i] = (hold_q[i] == HOLD_TC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      down_q  <= '0;
      up_q    <= '0;
      long_q  <= '0;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      down_q  <= down_d;
      up_q    <= up_d;
      long_q  <= long_d;
      for (int i = 0; i < N; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
      end
    end
  end

  assign level      = level_q;
  assign down       = down_q;
  assign up         = up_q;
  assign long_press = long_q;

endmodule

// File: tb/tb_button_frontend.sv
// Bench for button_frontend: history-based reference model checked every cycle
// on an active-high and an active-low instance, plus directed literal checks.
module tb_button_frontend;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int MAXE = 8192;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_raw_n;
  logic [N-1:0] level, down, up, long_press;
  logic [N-1:0] level_al, down_al, up_al, long_al;

  int checks;
  int failures;

  assign btn_raw_n = ~btn_raw;

  button_frontend #(.N(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .PAD_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .level(level), .down(down), .up(up), .long_press(long_press));

  button_frontend #(.N(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .PAD_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_n),
    .level(level_al), .down(down_al), .up(up_al), .long_press(long_al));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pad history per edge, level flips when the DEB samples
  // seen by the debouncer all differ from level and none precede the last flip.
  int ecnt;
  int r0;
  int last_chg [N];
  int dn_edge [N];
  bit lvl [N];
  bit hist [N][MAXE];
  logic [N-1:0] e_lvl, e_dn, e_up, e_lp;

  function automatic bit samp(int ch, int k);
    if (k < 0 || k < r0) return 1'b0;
    return hist[ch][k];
  endfunction

  initial begin
    ecnt = 0;
    r0   = 0;
    e_lvl = '0; e_dn = '0; e_up = '0; e_lp = '0;
    for (int c = 0; c < N; c++) begin
      last_chg[c] = 0;
      dn_edge[c]  = -1000000;
      lvl[c]      = 1'b0;
    end
  end

  always @(posedge clk) begin
    logic [N-1:0] pad;
    int e;
    bit all_diff;
    pad  = btn_raw;
    ecnt = ecnt + 1;
    e    = ecnt;
    if (e >= MAXE) begin
      failures++;
      $display("FAIL model_history: got edge %0d expected below %0d", e, MAXE);
      $fatal(1, "history overflow");
    end
    if (!rst_n) begin
      r0 = e + 1;
      for (int c = 0; c < N; c++) begin
        last_chg[c] = e;
        dn_edge[c]  = -1000000;
        lvl[c]      = 1'b0;
      end
      e_lvl = '0; e_dn = '0; e_up = '0; e_lp = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        hist[c][e] = pad[c];
        e_dn[c] = 1'b0;
        e_up[c] = 1'b0;
        if (e - DEB >= last_chg[c]) begin
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++)
            if (samp(c, e - 2 - j) == lvl[c]) all_diff = 1'b0;
          if (all_diff) begin
            lvl[c]      = ~lvl[c];
            last_chg[c] = e;
            if (lvl[c]) begin
              e_dn[c]    = 1'b1;
              dn_edge[c] = e;
            end else begin
              e_up[c] = 1'b1;
            end
          end
        end
        e_lp[c]  = lvl[c] && (e - dn_edge[c] == LONG);
        e_lvl[c] = lvl[c];
      end
    end
    #1;
    chk("model_ah", {level, down, up, long_press}, {e_lvl, e_dn, e_up, e_lp});
    chk("model_al", {level_al, down_al, up_al, long_al}, {e_lvl, e_dn, e_up, e_lp});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
    btn_raw = '0;
    ticks(12);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn_raw  = '0;
    ticks(3);
    chk("reset_outputs", {level, down, up, long_press}, 32'h0);
    #2 rst_n = 1'b1;
    ticks(4);

    // Clean press on channel 0: level/down at edge 5, down gone at edge 6.
    btn_raw[0] = 1'b1;
    tick();
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("press_pre_level", {30'b0, level}, 32'h0);
    end
    tick();
    chk("press_level_e5", {30'b0, level}, 32'h1);
    chk("press_down_e5", {30'b0, down}, 32'h1);
    tick();
    chk("press_down_e6", {30'b0, down}, 32'h0);
    chk("press_up_e6", {30'b0, up}, 32'h0);
    settle();

    // Glitch of 3 samples, then repeated 3-high/1-low pulses.
    btn_raw[0] = 1'b1;
    ticks(3);
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch_quiet", {30'b0, level | down | up}, 32'h0);
    end
    for (int r = 0; r < 10; r++) begin
      btn_raw[0] = 1'b1;
      ticks(3);
      btn_raw[0] = 1'b0;
      tick();
      chk("pulse_train_quiet", {30'b0, level | down | up}, 32'h0);
    end
    settle();

    // Long press on channel 1.
    btn_raw[1] = 1'b1;
    ticks(6);
    chk("long_down_e5", {30'b0, down}, 32'h2);
    ticks(9);
    chk("long_pre_e14", {30'b0, long_press}, 32'h0);
    tick();
    chk("long_pulse_e15", {30'b0, long_press}, 32'h2);
    for (int k = 16; k <= 60; k++) begin
      tick();
      chk("long_no_repeat", {30'b0, long_press}, 32'h0);
    end
    btn_raw[1] = 1'b0;
    ticks(5);
    chk("long_up_pre", {30'b0, up}, 32'h0);
    tick();
    chk("long_up_e5", {30'b0, up}, 32'h2);
    settle();

    // Short press: level high exactly 8 cycles, no long-press; then a long hold.
    btn_raw[0] = 1'b1;
    ticks(6);
    chk("short_down", {30'b0, down}, 32'h1);
    ticks(2);
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("short_no_long", {30'b0, long_press}, 32'h0);
      chk("short_level_high", {30'b0, level}, 32'h1);
    end
    tick();
    chk("short_up_at_8", {30'b0, up}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("short_no_long_after", {30'b0, long_press}, 32'h0);
    end
    btn_raw[0] = 1'b1;
    ticks(6);
    chk("second_down", {30'b0, down}, 32'h1);
    ticks(9);
    chk("second_long_pre", {30'b0, long_press}, 32'h0);
    tick();
    chk("second_long_at_10", {30'b0, long_press}, 32'h1);
    settle();

    // Asynchronous reset with hold count 7, pad still held afterwards.
    btn_raw[0] = 1'b1;
    ticks(6);
    chk("rst_test_down", {30'b0, down}, 32'h1);
    ticks(7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {level, down, up, long_press}, 32'h0);
    chk("async_reset_clear_al", {level_al, down_al, up_al, long_al}, 32'h0);
    ticks(2);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_quiet", {30'b0, level | down | up}, 32'h0);
    end
    tick();
    chk("post_rst_down", {30'b0, down}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_no_up", {30'b0, up}, 32'h0);
    end
    settle();

    // Simultaneous press on both channels; active-low instance sees pads at 0.
    btn_raw = 2'b11;
    ticks(6);
    chk("simul_down", {30'b0, down}, 32'h3);
    chk("simul_down_al", {30'b0, down_al}, 32'h3);
    chk("simul_level_al", {30'b0, level_al}, 32'h3);
    settle();

    // Randomized run lengths with occasional asynchronous reset.
    begin
      int run [N];
      for (int c = 0; c < N; c++) run[c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int c = 0; c < N; c++) begin
          if (run[c] == 0) begin
            int sel;
            btn_raw[c] = ~btn_raw[c];
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      run[c] = int'($urandom_range(1, 5));
            else if (sel == 1) run[c] = int'($urandom_range(6, 14));
            else               run[c] = int'($urandom_range(15, 60));
          end else begin
            run[c] = run[c] - 1;
          end
        end
        if ($urandom_range(0, 599) == 0) begin
          #2 rst_n = 1'b0;
          ticks(int'($urandom_range(1, 3)));
          #2 rst_n = 1'b1;
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
